s298_sig_compactor: RTL and testbench

- Downstream observation stage for the s298 sequential benchmark core.
- Samples the core's six registered outputs every clock for a programmed number of cycles.
- Compacts them into a multiple-input signature register (MISR) and counts output bit toggles.
- Presents the result with a done/ack handshake, so on-chip results can be compared against golden values during FPGA bring-up of the benchmark flow.

---
 rtl/s298_sig_compactor.sv | 95 +++++++++
 tb/tb_s298_sig_compactor.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/s298_sig_compactor.sv
// Observation stage for the s298 core: compacts six core outputs into a MISR
// signature and a saturating toggle count, then holds the result until acked.
module s298_sig_compactor #(
  parameter int              SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY = 16'h1021,
  parameter logic [SIG_W-1:0] SEED = 16'hFFFF,
  parameter int              CNT_W = 8,
  parameter int              TOG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       obs_in,
  input  logic             start,
  input  logic [CNT_W-1:0] num_cycles,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] sig,
  output logic [TOG_W-1:0] toggle_cnt
);

  // state | meaning
  // IDLE  | waiting for start; last result stays visible
  // RUN   | compacting one obs_in sample per clock
  // DONE  | result valid, waiting for ack
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] remaining;
  logic [5:0]       prev_obs;
  logic [5:0]       diff;
  logic [2:0]       pop;
  logic [TOG_W:0]   tog_sum;
  logic [TOG_W-1:0] tog_next;
  logic [SIG_W-1:0] misr_next;

  assign diff = obs_in ^ prev_obs;

  always_comb begin
    pop = '0;
    for (int i = 0; i < 6; i++) begin
      pop = pop + {2'b00, diff[i]};
    end
  end

  // At most 6 toggles per cycle, so one carry bit is enough to detect overflow.
  assign tog_sum  = {1'b0, toggle_cnt} + (TOG_W+1)'(pop);
  assign tog_next = tog_sum[TOG_W] ? '1 : tog_sum[TOG_W-1:0];

  assign misr_next = {sig[SIG_W-2:0], 1'b0}
                   ^ (sig[SIG_W-1] ? POLY : '0)
                   ^ SIG_W'(obs_in);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sig        <= '0;
      toggle_cnt <= '0;
      remaining  <= '0;
      prev_obs   <= '0;
    end else begin
      prev_obs <= obs_in;
      case (state)
        IDLE: begin
          if (start) begin
            sig        <= SEED;
            toggle_cnt <= '0;
            if (num_cycles != '0) begin
              remaining <= num_cycles;
              state     <= RUN;
            end else begin
              state <= DONE;
            end
          end
        end
        RUN: begin
          sig        <= misr_next;
          toggle_cnt <= tog_next;
          remaining  <= remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) state <= DONE;
        end
        DONE: begin
          if (ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_s298_sig_compactor.sv
// Self-checking bench for s298_sig_compactor: table of captures scored through
// an expected-result queue, plus hand sequences for reset and handshake corners.
module tb_s298_sig_compactor;

  logic        clk;
  logic        rst_n;
  logic [5:0]  obs_in;
  logic        start;
  logic [7:0]  num_cycles;
  logic        ack;
  logic        busy;
  logic        done;
  logic [15:0] sig;
  logic [7:0]  toggle_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] sig;
    logic [7:0]  tog;
  } result_t;

  typedef struct {
    int          n;
    logic [5:0]  a;
    logic [5:0]  b;
    logic [5:0]  pre;
    bit          has_sig;
    logic [15:0] sig;
    bit          has_tog;
    logic [7:0]  tog;
  } cap_vec_t;

  result_t sb[$];
  cap_vec_t vecs[6];

  s298_sig_compactor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .obs_in     (obs_in),
    .start      (start),
    .num_cycles (num_cycles),
    .ack        (ack),
    .busy       (busy),
    .done       (done),
    .sig        (sig),
    .toggle_cnt (toggle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [5:0] o);
    logic [15:0] r;
    r = {s[14:0], 1'b0};
    if (s[15]) r = r ^ 16'h1021;
    return r ^ {10'd0, o};
  endfunction

  function automatic int popc(input logic [5:0] v);
    int c = 0;
    for (int i = 0; i < 6; i++) c += int'(v[i]);
    return c;
  endfunction

  // Drives one capture, expects done after exactly n sample edges.
  task automatic capture(input cap_vec_t v, input bit pulse_start);
    result_t     exp_r;
    result_t     got_r;
    logic [15:0] s;
    int          t;
    logic [5:0]  p;
    logic [5:0]  o;
    s = 16'hFFFF; t = 0; p = v.pre;
    for (int i = 0; i < v.n; i++) begin
      o = (i % 2 == 0) ? v.a : v.b;
      s = misr(s, o);
      t = t + popc(o ^ p);
      if (t > 255) t = 255;
      p = o;
    end
    exp_r.sig = v.has_sig ? v.sig : s;
    exp_r.tog = v.has_tog ? v.tog : 8'(t);
    sb.push_back(exp_r);

    obs_in = v.pre; start = 1'b1; num_cycles = 8'(v.n);
    step();
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, {31'd0, v.n != 0});
    for (int i = 0; i < v.n; i++) begin
      obs_in = (i % 2 == 0) ? v.a : v.b;
      if (pulse_start && i == 1) begin
        start = 1'b1; num_cycles = 8'd0;
      end else begin
        start = 1'b0;
      end
      step();
      if (i < v.n - 1) check("busy_run", {31'd0, busy}, 32'd1);
    end
    start = 1'b0;
    check("done_at_end", {31'd0, done}, 32'd1);
    check("busy_at_end", {31'd0, busy}, 32'd0);
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      got_r = sb.pop_front();
      check("sig_result", {16'd0, sig}, {16'd0, got_r.sig});
      check("tog_result", {24'd0, toggle_cnt}, {24'd0, got_r.tog});
    end
  endtask

  task automatic do_ack(input logic [15:0] hold_sig);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("done_after_ack", {31'd0, done}, 32'd0);
    check("sig_hold_idle", {16'd0, sig}, {16'd0, hold_sig});
  endtask

  initial begin
    logic [15:0] held;
    rst_n = 1'b0; obs_in = '0; start = 1'b0; num_cycles = '0; ack = 1'b0;

    vecs[0] = '{n:1,   a:6'h00, b:6'h00, pre:6'h00, has_sig:1, sig:16'hEFDF, has_tog:1, tog:8'd0};
    vecs[1] = '{n:0,   a:6'h00, b:6'h00, pre:6'h00, has_sig:1, sig:16'hFFFF, has_tog:1, tog:8'd0};
    vecs[2] = '{n:4,   a:6'h3F, b:6'h00, pre:6'h00, has_sig:0, sig:16'h0,    has_tog:1, tog:8'd24};
    vecs[3] = '{n:64,  a:6'h3F, b:6'h00, pre:6'h00, has_sig:0, sig:16'h0,    has_tog:1, tog:8'd255};
    vecs[4] = '{n:7,   a:6'h15, b:6'h2A, pre:6'h3F, has_sig:0, sig:16'h0,    has_tog:0, tog:8'd0};
    vecs[5] = '{n:255, a:6'h01, b:6'h02, pre:6'h00, has_sig:0, sig:16'h0,    has_tog:1, tog:8'd255};

    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sig", {16'd0, sig}, 32'd0);
    check("rst_tog", {24'd0, toggle_cnt}, 32'd0);
    rst_n = 1'b1;
    step();

    ack = 1'b1;
    step();
    ack = 1'b0;
    check("ack_idle_done", {31'd0, done}, 32'd0);
    check("ack_idle_busy", {31'd0, busy}, 32'd0);

    foreach (vecs[i]) begin
      capture(vecs[i], 1'b0);
      held = sig;
      do_ack(held);
    end

    // Two samples: intermediate signature, then a long hold with ack low.
    obs_in = 6'h00; start = 1'b1; num_cycles = 8'd2;
    step();
    start = 1'b0;
    step();
    check("two_mid_sig", {16'd0, sig}, 32'h0000EFDF);
    check("two_mid_busy", {31'd0, busy}, 32'd1);
    step();
    check("two_done", {31'd0, done}, 32'd1);
    check("two_sig", {16'd0, sig}, 32'h0000CF9F);
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_done", {31'd0, done}, 32'd1);
      check("hold_sig", {16'd0, sig}, 32'h0000CF9F);
    end

    // Start pulsed in DONE is ignored; start together with ack only acks.
    start = 1'b1; num_cycles = 8'd3;
    step();
    check("start_in_done", {31'd0, done}, 32'd1);
    check("start_in_done_sig", {16'd0, sig}, 32'h0000CF9F);
    ack = 1'b1;
    step();
    ack = 1'b0; start = 1'b0;
    check("start_ack_done", {31'd0, done}, 32'd0);
    check("start_ack_busy", {31'd0, busy}, 32'd0);
    check("start_ack_sig", {16'd0, sig}, 32'h0000CF9F);
    step();
    check("idle_stays", {31'd0, busy | done}, 32'd0);
    start = 1'b1; num_cycles = 8'd1; obs_in = 6'h00;
    step();
    start = 1'b0;
    check("restart_seed", {16'd0, sig}, 32'h0000FFFF);
    check("restart_busy", {31'd0, busy}, 32'd1);
    step();
    check("restart_sig", {16'd0, sig}, 32'h0000EFDF);
    do_ack(16'hEFDF);

    // Start pulsed during RUN must not disturb the capture.
    capture(vecs[4], 1'b1);
    do_ack(sig);

    // Asynchronous reset between edges mid-RUN.
    obs_in = 6'h2A; start = 1'b1; num_cycles = 8'd10;
    step();
    start = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_sig", {16'd0, sig}, 32'd0);
    check("arst_tog", {24'd0, toggle_cnt}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_done", {31'd0, done}, 32'd0);
    capture(vecs[0], 1'b0);
    do_ack(16'hEFDF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
